// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: run/pause/expire countdown timer driven by a gated 1-cycle prescaler tick.
// Optional feature macro AUTO_RELOAD_EN: on expiry, restart from the last loaded value instead of stopping.
module countdown_timer_ctrl #(
  parameter logic [31:0] TICK_DIV = 32'd50000000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       state,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_PAUSE   = 2'b10,
    S_EXPIRED = 2'b11
  } state_t;

  localparam logic [31:0] PRESC_LAST = TICK_DIV - 32'd1;

  state_t           r_state;
  logic [31:0]      r_presc;
  logic [CNT_W-1:0] r_remaining;
  logic             r_tick;
  logic             r_done;
`ifdef AUTO_RELOAD_EN
  logic [CNT_W-1:0] r_reload;
`endif

  logic w_go;
  logic w_hold;
  logic w_wrap;
  logic w_last;

  // start and pause together cancel each other out in every state
  assign w_go   = start & ~pause;
  assign w_hold = pause & ~start;
  assign w_wrap = (r_presc == PRESC_LAST);
  assign w_last = (r_remaining == CNT_W'(1));

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_remaining <= '0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_reload    <= '0;
`endif
    end else if (load) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_remaining <= load_val;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_reload    <= load_val;
`endif
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go && (r_remaining != '0)) begin
            r_state <= S_RUN;
            r_presc <= '0;
          end
        end
        S_RUN: begin
          if (w_wrap) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            if (w_last) begin
              r_done <= 1'b1;
`ifdef AUTO_RELOAD_EN
              if (r_reload != '0) begin
                r_remaining <= r_reload;
                if (w_hold) r_state <= S_PAUSE;
              end else begin
                r_remaining <= '0;
                r_state     <= S_EXPIRED;
              end
`else
              r_remaining <= '0;
              r_state     <= S_EXPIRED;
`endif
            end else begin
              // a pause landing on the wrap edge still lets this decrement through
              r_remaining <= dec_sat(r_remaining);
              if (w_hold) r_state <= S_PAUSE;
            end
          end else begin
            r_presc <= r_presc + 32'd1;
            if (w_hold) r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_go) r_state <= S_RUN;
        end
        S_EXPIRED: begin
          r_presc <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tick      = r_tick;
  assign done      = r_done;
  assign remaining = r_remaining;
  assign state     = r_state;

endmodule
